// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand forwarding/selection (optional EX_FORWARDING_EN)
module ex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_alu_control,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  in_left_sel,
    input  logic                  in_right_sel,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_reg_write,
    input  logic                  mem_fwd_we,
    input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]       mem_fwd_data,
    input  logic                  wb_fwd_we,
    input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]       wb_fwd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_alu_control,
    output logic [XLEN-1:0]       out_left,
    output logic [XLEN-1:0]       out_right,
    output logic [XLEN-1:0]       out_store_data,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write
);

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic [3:0]            alu_control_q;
    logic [XLEN-1:0]       left_q, right_q, store_data_q, pc_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;

    logic                  load;
    logic [XLEN-1:0]       fwd_rs1, fwd_rs2;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

`ifdef EX_FORWARDING_EN
    // MEM/EX result is younger than MEM/WB, so it wins; x0 is hardwired zero.
    always_comb begin
        fwd_rs1 = in_rs1_data;
        if (mem_fwd_we && mem_fwd_rd == in_rs1_addr && in_rs1_addr != '0)
            fwd_rs1 = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_rd == in_rs1_addr && in_rs1_addr != '0)
            fwd_rs1 = wb_fwd_data;
    end

    always_comb begin
        fwd_rs2 = in_rs2_data;
        if (mem_fwd_we && mem_fwd_rd == in_rs2_addr && in_rs2_addr != '0)
            fwd_rs2 = mem_fwd_data;
        else if (wb_fwd_we && wb_fwd_rd == in_rs2_addr && in_rs2_addr != '0)
            fwd_rs2 = wb_fwd_data;
    end
`else
    // Decode stalls cover hazards here, so the forwarding bus is deliberately ignored.
    logic unused_fwd;
    assign unused_fwd = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd,
                          wb_fwd_data, in_rs1_addr, in_rs2_addr};
    assign fwd_rs1 = in_rs1_data;
    assign fwd_rs2 = in_rs2_data;
`endif

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (load) begin
            valid_d     = 1'b1;
            reg_write_d = in_reg_write;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            alu_control_q <= 4'b0000;
            left_q        <= '0;
            right_q       <= '0;
            store_data_q  <= '0;
            pc_q          <= '0;
            rd_addr_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            if (load) begin
                alu_control_q <= in_alu_control;
                left_q        <= in_left_sel  ? in_pc  : fwd_rs1;
                right_q       <= in_right_sel ? in_imm : fwd_rs2;
                store_data_q  <= fwd_rs2;
                pc_q          <= in_pc;
                rd_addr_q     <= in_rd_addr;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_reg_write   = valid_q && reg_write_q;
    assign out_alu_control = alu_control_q;
    assign out_left        = left_q;
    assign out_right       = right_q;
    assign out_store_data  = store_data_q;
    assign out_pc          = pc_q;
    assign out_rd_addr     = rd_addr_q;

endmodule
